fdtd_mem_wt_burst: RTL and testbench
====================================

# fdtd_mem_wt_burst

Parametrised AXI4 write master for the FDTD plugin that streams a write job to memory. A job is one command (start byte address, word count) plus a stream of data words. The block buffers data in an internal FIFO and splits the job into INCR bursts of up to MAX_BURST beats, never crossing a 4 KB boundary. It replaces the single-request write path with a command/stream interface, adds response-error reporting, and supports jobs larger than one burst.

## Interface
- AXI4_ADDR_WIDTH, 32, AXI address width
- AXI4_DATA_WIDTH, 32, data width; BYTES = AXI4_DATA_WIDTH/8 (power of 2)
- AXI4_ID_WIDTH, 16, ID width
- AXI4_USER_WIDTH, 10, user width
- FIFO_DEPTH, 16, data FIFO entries (power of 2, ≥ 2)
- MAX_BURST, 16, max beats per burst (1..256)
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- AW*_o / AWVALID_o / AWREADY_i  AXI4 write-address channel
  - AWID = 0, AWSIZE = log2(BYTES), AWBURST = INCR, all other sideband 0
- WDATA_o / WSTRB_o / WLAST_o / WUSER_o / WVALID_o / WREADY_i  AXI4 write-data channel
  - WSTRB all ones, WUSER = 0
- BID_i / BRESP_i / BUSER_i / BVALID_i / BREADY_o  AXI4 write-response channel
- cmd_valid_i  in  1  job request
- cmd_ready_o  out  1  high only in IDLE
- cmd_addr_i  in  AXI4_ADDR_WIDTH  start byte address; low log2(BYTES) bits ignored (treated as 0)
- cmd_len_i  in  16  job length in words
- wdata_valid_i  in  1  data word valid
- wdata_ready_o  out  1  = FIFO not full
- wdata_i  in  AXI4_DATA_WIDTH  data word
- busy_o  out  1  high whenever the state is not IDLE
- done_o  out  1  one-cycle pulse when a job completes
- err_o  out  1  sticky; set by any BRESP of SLVERR or DECERR; cleared when the next command is accepted

## Operation
- **FIFO**
  - Pushes whenever wdata_valid_i && wdata_ready_o, in any state, so data may arrive before its command.
  - Pops on each W handshake (WVALID_o && WREADY_i).
  - No push occurs at full; a pop and a push in the same cycle are legal when not full.
- **Job registers:** addr_q (current burst address) and rem_q (words remaining, 16-bit).
- **Burst size.** beats = min(rem_q, MAX_BURST, pg), where pg = (4096 − addr_q[11:0]) / BYTES.
  - AWLEN_o = beats − 1; AWADDR_o = addr_q.
  - After AW handshake: addr_q += beats·BYTES, rem_q −= beats, beat counter loaded with beats.
- **FSM states: IDLE, AW, W, B.**
  - IDLE
    - cmd_valid_i with cmd_len_i ≠ 0: clear err_o, latch the command, go to AW.
    - cmd_valid_i with cmd_len_i = 0: accept the command, pulse done_o next cycle, stay in IDLE, no AXI traffic.
  - AW: AWVALID_o = 1 until AWREADY_i. Address and length are stable while valid. On handshake, go to W.
  - W
    - WVALID_o = FIFO not empty; WDATA_o = FIFO head.
    - WLAST_o = WVALID_o && beat counter == 1. The counter decrements on each handshake.
    - Handshake with WLAST_o goes to B.
  - B
    - BREADY_o = 1 (0 in all other states).
    - On BVALID_i, OR BRESP_i[1] into err_o.
    - Then: if rem_q ≠ 0, go to AW; otherwise pulse done_o and go to IDLE.
- One outstanding transaction at a time. AW and W of the same burst never overlap.
- **Reset** (at any time, including mid-burst)
  - State = IDLE; FIFO emptied.
  - AWVALID_o, WVALID_o, WLAST_o, BREADY_o, done_o, err_o, busy_o = 0.
  - cmd_ready_o = 1; wdata_ready_o = 1 from the first cycle after reset.
  - A burst in flight is abandoned; the interconnect is reset alongside this block.

## Timing
- Command accepted at edge N → AWVALID_o high in cycle N+1.
- AW handshake at edge M → W state from M+1. WVALID_o rises the same cycle if the FIFO is non-empty.
- Back-to-back beats with WREADY_i held high and data available: one beat per cycle.
- B handshake at edge K:
  - next burst AWVALID_o in cycle K+1; or
  - done_o high during cycle K+1 and cmd_ready_o high from K+1.
- FIFO latency: a word pushed at edge P is visible at the FIFO head from cycle P+1.
- All outputs are registered or decoded from the registered state; no combinational path from any AXI *READY input to a *VALID output.

## Configuration
- **FDTD_WT_4K_SPLIT_EN**
  - Defined: the pg term is included in the burst-size minimum, so no burst crosses a 4 KB boundary.
  - Undefined: beats = min(rem_q, MAX_BURST). Software must guarantee that no burst crosses 4 KB. Saves the page-offset subtractor and divider.

## Test plan
- addr 0x1000_0000, len 16, 16 words preloaded, ready always high → one burst, AWLEN 15, 16 consecutive beats, WLAST on beat 16, done_o one cycle after BVALID.
- len 40, MAX_BURST 16 → three bursts, AWLEN 15/15/7, AWADDR 0x…000 / 0x…040 / 0x…080.
- (macro on) addr 0x0000_0FF8, len 8 → AWLEN 1 at 0xFF8, then AWLEN 5 at 0x1000. Macro off → single burst AWLEN 7.
- Data trickled 1 word every 3 cycles, WREADY toggled randomly → WVALID_o drops when the FIFO is empty, data order preserved, no lost or duplicated beats.
- BRESP = SLVERR on the second of two bursts → err_o set, job still completes with done_o. Next command accepted → err_o cleared.
- ARESET asserted mid-burst (beat 5 of 16) → the next cycle shows IDLE, all valids 0, FIFO empty. A new len-4 job then completes normally.

Source files
------------

// File: rtl/fdtd_mem_wt_burst.sv
// fdtd_mem_wt_burst: AXI4 write master that buffers a word stream and splits a job into INCR bursts.
// Define FDTD_WT_4K_SPLIT_EN to also cap each burst at the next 4 KB boundary.
module fdtd_mem_wt_burst #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI4_ID_WIDTH = 16,
  parameter int AXI4_USER_WIDTH = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST = 16
) (
  input  logic ACLK,
  input  logic ARESET,
  output logic [AXI4_ID_WIDTH-1:0] AWID_o,
  output logic [AXI4_ADDR_WIDTH-1:0] AWADDR_o,
  output logic [7:0] AWLEN_o,
  output logic [2:0] AWSIZE_o,
  output logic [1:0] AWBURST_o,
  output logic AWLOCK_o,
  output logic [3:0] AWCACHE_o,
  output logic [2:0] AWPROT_o,
  output logic [3:0] AWQOS_o,
  output logic [3:0] AWREGION_o,
  output logic [AXI4_USER_WIDTH-1:0] AWUSER_o,
  output logic AWVALID_o,
  input  logic AWREADY_i,
  output logic [AXI4_DATA_WIDTH-1:0] WDATA_o,
  output logic [AXI4_DATA_WIDTH/8-1:0] WSTRB_o,
  output logic WLAST_o,
  output logic [AXI4_USER_WIDTH-1:0] WUSER_o,
  output logic WVALID_o,
  input  logic WREADY_i,
  input  logic [AXI4_ID_WIDTH-1:0] BID_i,
  input  logic [1:0] BRESP_i,
  input  logic [AXI4_USER_WIDTH-1:0] BUSER_i,
  input  logic BVALID_i,
  output logic BREADY_o,
  input  logic cmd_valid_i,
  output logic cmd_ready_o,
  input  logic [AXI4_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [15:0] cmd_len_i,
  input  logic wdata_valid_i,
  output logic wdata_ready_o,
  input  logic [AXI4_DATA_WIDTH-1:0] wdata_i,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);
  localparam int BYTES = AXI4_DATA_WIDTH / 8;
  localparam int SZ = $clog2(BYTES);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  state_t st, nxt;
  logic [AXI4_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  logic [AXI4_ADDR_WIDTH-1:0] addr_q;
  logic [15:0] rem_q;
  logic [8:0] cnt, beats;
  logic [16:0] lim, beats_w;
  logic empty, push, pop, acc, aw_hs, b_hs;
  logic unused;
  assign unused = ^{BID_i, BUSER_i, BRESP_i[0], beats_w[16:9]};
  assign empty = wp == rp;
  assign wdata_ready_o = !(wp[PW] != rp[PW] && wp[PW-1:0] == rp[PW-1:0]);
  assign push = wdata_valid_i && wdata_ready_o;
  assign pop = WVALID_o && WREADY_i;
  assign acc = cmd_valid_i && cmd_ready_o;
  assign aw_hs = AWVALID_o && AWREADY_i;
  assign b_hs = BVALID_i && BREADY_o;
  assign cmd_ready_o = st == IDLE;
  assign busy_o = st != IDLE;
  assign AWVALID_o = st == AW;
  assign WVALID_o = st == W && !empty;
  assign WLAST_o = WVALID_o && cnt == 9'd1;
  assign BREADY_o = st == B;
  assign WDATA_o = mem[rp[PW-1:0]];
  assign AWID_o = '0;
  assign AWADDR_o = addr_q;
  assign AWLEN_o = 8'(beats - 9'd1);
  assign AWSIZE_o = 3'(SZ);
  assign AWBURST_o = 2'b01;
  assign AWLOCK_o = 1'b0;
  assign AWCACHE_o = 4'd0;
  assign AWPROT_o = 3'd0;
  assign AWQOS_o = 4'd0;
  assign AWREGION_o = 4'd0;
  assign AWUSER_o = '0;
  assign WSTRB_o = '1;
  assign WUSER_o = '0;
`ifdef FDTD_WT_4K_SPLIT_EN
  logic [12:0] pg;
  assign pg = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;
  assign lim = {4'd0, pg} < 17'(MAX_BURST) ? {4'd0, pg} : 17'(MAX_BURST);
`else
  assign lim = 17'(MAX_BURST);
`endif
  assign beats_w = {1'b0, rem_q} < lim ? {1'b0, rem_q} : lim;
  assign beats = beats_w[8:0];
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = cmd_valid_i && cmd_len_i != 16'd0 ? AW : IDLE;
      AW: nxt = AWREADY_i ? W : AW;
      W: nxt = pop && WLAST_o ? B : W;
      B: nxt = BVALID_i ? (rem_q != 16'd0 ? AW : IDLE) : B;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge ACLK)
    if (push) mem[wp[PW-1:0]] <= wdata_i;
  // Reset drops any burst in flight; the FIFO is emptied through its pointers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      st <= IDLE;
      wp <= '0;
      rp <= '0;
      addr_q <= '0;
      rem_q <= '0;
      cnt <= '0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      st <= nxt;
      done_o <= (acc && cmd_len_i == 16'd0) || (b_hs && rem_q == 16'd0);
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (pop) cnt <= cnt - 9'd1;
      if (acc) begin
        addr_q <= cmd_addr_i & ~AXI4_ADDR_WIDTH'(BYTES - 1);
        rem_q <= cmd_len_i;
      end
      if (aw_hs) begin
        addr_q <= addr_q + (AXI4_ADDR_WIDTH'(beats) << SZ);
        rem_q <= rem_q - 16'(beats);
        cnt <= beats;
      end
      if (acc) err_o <= 1'b0;
      else if (b_hs && BRESP_i[1]) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fdtd_mem_wt_burst.sv
// tb_fdtd_mem_wt_burst: table-driven and randomized jobs against a burst-splitting reference model.
// Expectations follow FDTD_WT_4K_SPLIT_EN when it is defined for the build.
module tb_fdtd_mem_wt_burst;
  logic ACLK = 1'b0, ARESET;
  logic [15:0] AWID_o;
  logic [31:0] AWADDR_o;
  logic [7:0] AWLEN_o;
  logic [2:0] AWSIZE_o;
  logic [1:0] AWBURST_o;
  logic AWLOCK_o;
  logic [3:0] AWCACHE_o;
  logic [2:0] AWPROT_o;
  logic [3:0] AWQOS_o;
  logic [3:0] AWREGION_o;
  logic [9:0] AWUSER_o;
  logic AWVALID_o, AWREADY_i;
  logic [31:0] WDATA_o;
  logic [3:0] WSTRB_o;
  logic WLAST_o;
  logic [9:0] WUSER_o;
  logic WVALID_o, WREADY_i;
  logic [15:0] BID_i;
  logic [1:0] BRESP_i;
  logic [9:0] BUSER_i;
  logic BVALID_i, BREADY_o;
  logic cmd_valid_i, cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_len_i;
  logic wdata_valid_i, wdata_ready_o;
  logic [31:0] wdata_i;
  logic busy_o, done_o, err_o;

  fdtd_mem_wt_burst dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID_o(AWID_o), .AWADDR_o(AWADDR_o), .AWLEN_o(AWLEN_o), .AWSIZE_o(AWSIZE_o),
    .AWBURST_o(AWBURST_o), .AWLOCK_o(AWLOCK_o), .AWCACHE_o(AWCACHE_o), .AWPROT_o(AWPROT_o),
    .AWQOS_o(AWQOS_o), .AWREGION_o(AWREGION_o), .AWUSER_o(AWUSER_o),
    .AWVALID_o(AWVALID_o), .AWREADY_i(AWREADY_i),
    .WDATA_o(WDATA_o), .WSTRB_o(WSTRB_o), .WLAST_o(WLAST_o), .WUSER_o(WUSER_o),
    .WVALID_o(WVALID_o), .WREADY_i(WREADY_i),
    .BID_i(BID_i), .BRESP_i(BRESP_i), .BUSER_i(BUSER_i), .BVALID_i(BVALID_i), .BREADY_o(BREADY_o),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_len_i(cmd_len_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0, fails = 0;
  logic [31:0] ea[$];
  int el[$];
  int g_ab, g_cmd, g_aw, g_w0, g_w1;
  logic [7:0] g_awlen0;

  typedef struct {
    logic [31:0] addr;
    int len;
    bit pre, trk, rnd;
    int eb, nb;
    logic [7:0] len0;
  } vec_t;
  vec_t tab[8];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Reference split: each burst takes as many words as the caps allow, in address order.
  function automatic void model(input logic [31:0] a, input int n);
    ea.delete();
    el.delete();
    a = a & ~32'h3;
    while (n > 0) begin
      int b = n < 16 ? n : 16;
`ifdef FDTD_WT_4K_SPLIT_EN
      int pg = (4096 - int'(a % 4096)) / 4;
      if (pg < b) b = pg;
`endif
      ea.push_back(a);
      el.push_back(b);
      a = a + 32'(b * 4);
      n = n - b;
    end
  endfunction

  task automatic idle_inputs();
    cmd_valid_i = 0; cmd_addr_i = 0; cmd_len_i = 0;
    wdata_valid_i = 0; wdata_i = 0;
    AWREADY_i = 0; WREADY_i = 0;
    BVALID_i = 0; BRESP_i = 0; BID_i = 0; BUSER_i = 0;
  endtask

  task automatic run_job(input logic [31:0] addr, input int len, input bit pre, trk, rnd,
                         input int eb, input int rst_at);
    logic [31:0] dq[$];
    int pushed = 0, wi = 0, ab = 0, bb = 0, cyc = 0, inb = 0, viol = 0;
    bit sent = 0, bpend = 0, dnext = 0, errnext = 0, fin = 0, brk = 0, xl;
    model(addr, len);
    for (int i = 0; i < len; i++) dq.push_back($urandom);
    g_ab = 0; g_awlen0 = 8'hFF; g_cmd = -1; g_aw = -1; g_w0 = -1; g_w1 = -1;
    while (!fin && !brk && cyc < 3000) begin
      @(negedge ACLK);
      if (dnext) begin
        chk("done_pulse", done_o, 1);
        chk("idle_after_done", {busy_o, cmd_ready_o}, 2'b01);
        fin = 1;
      end else if (done_o) viol++;
      if (errnext) chk("err_clear", err_o, 0);
      dnext = 0;
      errnext = 0;
      if (!fin) begin
        cmd_valid_i = !sent && (!pre || pushed == len);
        cmd_addr_i = addr;
        cmd_len_i = 16'(len);
        wdata_valid_i = pushed < len && (!trk || cyc % 3 == 0);
        wdata_i = pushed < len ? dq[pushed] : 32'd0;
        AWREADY_i = !rnd || $urandom_range(0, 1) == 1;
        WREADY_i = !rnd || $urandom_range(0, 2) != 0;
        BVALID_i = bpend && (!rnd || $urandom_range(0, 1) == 1);
        BRESP_i = bb == eb ? 2'b10 : 2'b00;
        #1;
        if (AWVALID_o && WVALID_o) viol++;
        if (WVALID_o && pushed == wi) viol++;
        if (cmd_valid_i && cmd_ready_o) begin
          sent = 1; errnext = 1; g_cmd = cyc;
          if (len == 0) dnext = 1;
        end
        if (wdata_valid_i && wdata_ready_o) pushed++;
        if (AWVALID_o && AWREADY_i) begin
          if (ab < ea.size()) begin
            chk("awaddr", AWADDR_o, ea[ab]);
            chk("awlen", AWLEN_o, 8'(el[ab] - 1));
            chk("awsize_burst", {AWSIZE_o, AWBURST_o}, 5'b010_01);
          end else viol++;
          if (ab == 0) begin g_awlen0 = AWLEN_o; g_aw = cyc; end
          ab++;
          inb = 0;
        end
        if (WVALID_o && WREADY_i) begin
          chk("wdata", WDATA_o, wi < len ? dq[wi] : 32'hDEAD_BEEF);
          inb++;
          xl = (ab >= 1 && ab <= el.size()) ? (inb == el[ab-1]) : 1'b0;
          chk("wlast", WLAST_o, xl);
          if (wi == 0) g_w0 = cyc;
          g_w1 = cyc;
          if (WLAST_o) bpend = 1;
          wi++;
          if (wi == rst_at) brk = 1;
        end
        if (BVALID_i && BREADY_o) begin
          bpend = 0;
          bb++;
          if (bb == ea.size()) dnext = 1;
        end
        cyc++;
      end
    end
    idle_inputs();
    g_ab = ab;
    if (brk) begin
      ARESET = 1;
      @(negedge ACLK);
      chk("rst_mid_burst",
          {busy_o, AWVALID_o, WVALID_o, WLAST_o, BREADY_o, done_o, err_o, cmd_ready_o, wdata_ready_o},
          9'b0000000_11);
      ARESET = 0;
    end else begin
      chk("job_finished", fin, 1);
      chk("burst_count", ab, ea.size());
      chk("beat_count", wi, len);
      chk("protocol", viol, 0);
      chk("err_sticky", err_o, eb >= 0 && eb < ea.size());
    end
  endtask

  initial begin
    idle_inputs();
    ARESET = 1;
    repeat (3) @(negedge ACLK);
    ARESET = 0;
    chk("reset_state",
        {busy_o, AWVALID_o, WVALID_o, WLAST_o, BREADY_o, done_o, err_o, cmd_ready_o, wdata_ready_o},
        9'b0000000_11);

    tab[0] = '{32'h1000_0000, 16, 1, 0, 0, -1, 1, 8'd15};
    tab[1] = '{32'h1000_0000, 40, 0, 0, 0, -1, 3, 8'd15};
`ifdef FDTD_WT_4K_SPLIT_EN
    tab[2] = '{32'h0000_0FF8, 8, 1, 0, 0, -1, 2, 8'd1};
`else
    tab[2] = '{32'h0000_0FF8, 8, 1, 0, 0, -1, 1, 8'd7};
`endif
    tab[3] = '{32'h2000_0100, 20, 0, 1, 1, -1, 2, 8'd15};
    tab[4] = '{32'h3000_0000, 32, 0, 0, 0, 1, 2, 8'd15};
    tab[5] = '{32'h3000_0040, 4, 0, 0, 0, -1, 1, 8'd3};
    tab[6] = '{32'h0000_0004, 0, 0, 0, 0, -1, 0, 8'hFF};
    tab[7] = '{32'h0000_0FF3, 4, 0, 0, 1, -1, 1, 8'd3};

    for (int i = 0; i < 8; i++) begin
      run_job(tab[i].addr, tab[i].len, tab[i].pre, tab[i].trk, tab[i].rnd, tab[i].eb, 0);
      chk($sformatf("tab%0d_nbursts", i), g_ab, tab[i].nb);
      chk($sformatf("tab%0d_awlen0", i), g_awlen0, tab[i].len0);
      if (i == 0) begin
        chk("cmd_to_aw", g_aw - g_cmd, 1);
        chk("aw_to_w", g_w0 - g_aw, 1);
        chk("w_consecutive", g_w1 - g_w0, 15);
      end
    end

    run_job(32'h4000_0000, 16, 1, 0, 0, -1, 5);
    run_job(32'h4000_1000, 4, 0, 0, 0, -1, 0);
    chk("after_rst_nbursts", g_ab, 1);

    for (int i = 0; i < 12; i++)
      run_job($urandom & 32'hFFFF_FFFC, $urandom_range(1, 48), 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)) - 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
